// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: requester count,
// index width, FSM state type and the one-hot to index helper.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Binary index of the set bit in a one-hot vector (0 for an all-zero vector).
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate the request vector so the search
// starts just after the previous winner, isolate the lowest set bit, and map
// the result back to an absolute requester index.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             any,
    output logic [ID_W-1:0]  winner
);

    logic [ID_W-1:0]    start;
    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [N_REQ-1:0]   first;
    logic [ID_W-1:0]    offset;

    // Rotate-mask-encode; the index wraps naturally in ID_W bits.
    always_comb begin
        start   = last + ID_W'(1);
        doubled = {req, req} >> start;
        rotated = doubled[N_REQ-1:0];
        first   = rotated & (~rotated + N_REQ'(1));
        offset  = onehot_to_idx(first);
        winner  = start + offset;
        any     = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for eight requesters sharing the 7-segment decode path.
// Grants one requester at a time, holds until release, then inserts one dead
// cycle before the next arbitration.
// Optional feature: define RR_ARB_TIMEOUT_EN to add the hold counter that
// force-releases a grant after MAX_HOLD cycles and pulses timeout.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N-1:0]    req,
    input  logic            rel,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id,
    output logic            timeout
);

    arb_state_t      state;
    logic [ID_W-1:0] last;
    logic            pick_any;
    logic [ID_W-1:0] pick_winner;
    logic            hold_limit;
    logic            release_now;
    logic            start_grant;

    rr_pick u_pick (
        .req    (req),
        .last   (last),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign start_grant = (state == IDLE) && ena && pick_any;
    assign release_now = rel || !req[gnt_id] || hold_limit;
    assign gnt_valid   = |gnt;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned     HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    assign hold_limit = (state == GRANT) && (hold_cnt == HOLD_LAST);

    // Hold counter: cleared on a new grant, counts held cycles, saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (start_grant) begin
            hold_cnt <= '0;
        end else if ((state == GRANT) && !release_now) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Timeout pulse coincides with the cycle in which the forced release drops gnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= hold_limit;
        end
    end
`else
    assign hold_limit = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Arbitration FSM: IDLE picks a winner, GRANT holds it, TURN is the dead cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            last   <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_grant) begin
                        gnt    <= N'(1) << pick_winner;
                        gnt_id <= pick_winner;
                        last   <= pick_winner;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt   <= '0;
                        state <= TURN;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
